led_array_ctl: RTL and testbench

LED_ARRAY_CTL -- requirements
Module: led_array_ctl

---
 rtl/led_array_ctl.sv | 95 +++++++++
 tb/tb_led_array_ctl.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/led_array_ctl.sv
// Multi-channel LED controller: per-channel select mask shown as steady, blinking,
// chasing or blanked, with the display mode stepped by a one-cycle mode pulse.
module led_array_ctl #(
    parameter int CH_NUM   = 4,
    parameter int TICK_DIV = 25_000_000,
    parameter int CNT_W    = 25
) (
    input  logic              sclk,
    input  logic              s_rst_n,
    input  logic [CH_NUM-1:0] key_flag,
    input  logic              mode_flag,
    output logic [CH_NUM-1:0] led,
    output logic [1:0]        mode
);

    typedef enum logic [1:0] {
        MODE_TOGGLE = 2'd0,
        MODE_BLINK  = 2'd1,
        MODE_CHASE  = 2'd2,
        MODE_OFF    = 2'd3
    } mode_e;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CH_NUM-1:0] RUN_INIT = CH_NUM'(1);

    mode_e             mode_q, mode_d;
    logic [CH_NUM-1:0] sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              phase_q, phase_d;
    logic [CH_NUM-1:0] run_q, run_d;
    logic [CH_NUM-1:0] led_q, led_d;
    logic [CH_NUM-1:0] run_rot;
    logic              pattern_on;
    logic              tick;

    // Left rotation; the modulo index keeps the single-channel case a plain wire.
    for (genvar g = 0; g < CH_NUM; g++) begin : g_rot
        assign run_rot[g] = run_q[(g + CH_NUM - 1) % CH_NUM];
    end

    always_comb begin
        sel_d      = sel_q ^ key_flag;
        mode_d     = mode_q;
        cnt_d      = cnt_q;
        phase_d    = phase_q;
        run_d      = run_q;
        led_d      = '0;
        tick       = 1'b0;
        pattern_on = (mode_q == MODE_BLINK) || (mode_q == MODE_CHASE);

        // Mode entry restarts the pattern and suppresses any tick on this cycle.
        if (mode_flag) begin
            mode_d  = mode_e'(mode_q + 2'd1);
            cnt_d   = '0;
            phase_d = 1'b1;
            run_d   = RUN_INIT;
        end else if (pattern_on) begin
            tick  = (cnt_q == CNT_LAST);
            cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
            if (tick && (mode_q == MODE_BLINK)) phase_d = ~phase_q;
            if (tick && (mode_q == MODE_CHASE)) run_d = run_rot;
        end else begin
            cnt_d = '0;
        end

        case (mode_d)
            MODE_TOGGLE: led_d = sel_d;
            MODE_BLINK:  led_d = phase_d ? sel_d : '0;
            MODE_CHASE:  led_d = run_d;
            default:     led_d = '0;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!s_rst_n) begin
            mode_q  <= MODE_TOGGLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b1;
            run_q   <= RUN_INIT;
            led_q   <= '0;
        end else begin
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            run_q   <= run_d;
            led_q   <= led_d;
        end
    end

    assign led  = led_q;
    assign mode = mode_q;

endmodule

// File: tb/tb_led_array_ctl.sv
// Self-checking bench for led_array_ctl: directed scenarios followed by random
// pulses, all compared against a cycle-count reference model.
module tb_led_array_ctl;

    localparam int CH_NUM   = 4;
    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 3;

    logic              sclk = 1'b0;
    logic              s_rst_n;
    logic [CH_NUM-1:0] key_flag;
    logic              mode_flag;
    logic [CH_NUM-1:0] led;
    logic [1:0]        mode;

    int tests_run = 0;
    int failed    = 0;

    // Reference model: mask, mode number, and edges elapsed since the last mode entry.
    logic [CH_NUM-1:0] m_sel;
    int                m_mode;
    int                m_elapsed;

    led_array_ctl #(
        .CH_NUM  (CH_NUM),
        .TICK_DIV(TICK_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .sclk     (sclk),
        .s_rst_n  (s_rst_n),
        .key_flag (key_flag),
        .mode_flag(mode_flag),
        .led      (led),
        .mode     (mode)
    );

    always #5 sclk = ~sclk;

    function automatic logic [CH_NUM-1:0] model_led();
        int ticks;
        ticks = m_elapsed / TICK_DIV;
        case (m_mode)
            0:       return m_sel;
            1:       return (ticks % 2 == 0) ? m_sel : '0;
            2:       return CH_NUM'(1) << (ticks % CH_NUM);
            default: return '0;
        endcase
    endfunction

    task automatic checkOutput(input string tag);
        logic [CH_NUM-1:0] exp_led;
        logic [1:0]        exp_mode;
        exp_led  = model_led();
        exp_mode = 2'(m_mode);
        tests_run++;
        assert (led === exp_led) else begin
            failed++;
            $error("[TB] FAIL %s led=%b expected %b", tag, led, exp_led);
        end
        tests_run++;
        assert (mode === exp_mode) else begin
            failed++;
            $error("[TB] FAIL %s mode=%0d expected %0d", tag, mode, exp_mode);
        end
    endtask

    // Drive one cycle of inputs, advance the model across the edge, then check.
    task automatic applyStimulus(input logic [CH_NUM-1:0] key, input logic mflag,
                                 input logic rst_n, input string tag);
        key_flag  = key;
        mode_flag = mflag;
        s_rst_n   = rst_n;
        @(posedge sclk);
        if (!rst_n) begin
            m_sel     = '0;
            m_mode    = 0;
            m_elapsed = 0;
        end else begin
            m_sel = m_sel ^ key;
            if (mflag) begin
                m_mode    = (m_mode + 1) % 4;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
        end
        #1;
        checkOutput(tag);
        key_flag  = '0;
        mode_flag = 1'b0;
        s_rst_n   = 1'b1;
    endtask

    initial begin
        key_flag  = '0;
        mode_flag = 1'b0;
        s_rst_n   = 1'b0;
        m_sel     = '0;
        m_mode    = 0;
        m_elapsed = 0;

        applyStimulus('0, 1'b0, 1'b0, "reset0");
        applyStimulus(4'b1111, 1'b1, 1'b0, "reset1");

        applyStimulus(4'b0101, 1'b0, 1'b1, "toggle_a");
        applyStimulus(4'b0001, 1'b0, 1'b1, "toggle_b");
        applyStimulus('0, 1'b0, 1'b1, "toggle_idle");

        applyStimulus(4'b0010, 1'b0, 1'b1, "sel_0110");
        applyStimulus('0, 1'b1, 1'b1, "blink_enter");
        for (int i = 0; i < 2 * 2 * TICK_DIV; i++) applyStimulus('0, 1'b0, 1'b1, "blink_run");

        applyStimulus('0, 1'b1, 1'b1, "chase_enter");
        for (int i = 0; i < CH_NUM * TICK_DIV; i++) applyStimulus('0, 1'b0, 1'b1, "chase_run");
        applyStimulus(4'b0011, 1'b0, 1'b1, "chase_key");
        for (int i = 0; i < TICK_DIV; i++) applyStimulus('0, 1'b0, 1'b1, "chase_after_key");

        applyStimulus('0, 1'b1, 1'b1, "off_enter");
        for (int i = 0; i < 3; i++) applyStimulus('0, 1'b0, 1'b1, "off_idle");
        applyStimulus('0, 1'b1, 1'b1, "wrap_toggle");
        applyStimulus('0, 1'b0, 1'b1, "wrap_idle");

        applyStimulus(4'b1000, 1'b1, 1'b1, "simul_key_mode");
        for (int i = 0; i < 5; i++) applyStimulus('0, 1'b0, 1'b1, "simul_after");

        // Step to CHASE and wait until the lit channel is bit 2, then reset.
        applyStimulus('0, 1'b1, 1'b1, "to_chase");
        for (int i = 0; i < 2 * TICK_DIV + 1; i++) applyStimulus('0, 1'b0, 1'b1, "chase_to_bit2");
        applyStimulus(4'b1111, 1'b0, 1'b0, "reset_mid_chase");
        for (int i = 0; i < 10; i++) applyStimulus('0, 1'b0, 1'b1, "post_reset_idle");

        // A reset pulse that never spans a rising edge must be ignored.
        applyStimulus(4'b1010, 1'b0, 1'b1, "pre_glitch");
        #2 s_rst_n = 1'b0;
        #2 s_rst_n = 1'b1;
        applyStimulus('0, 1'b0, 1'b1, "rst_glitch");

        for (int i = 0; i < 400; i++) begin
            logic [CH_NUM-1:0] k;
            logic              mf;
            logic              rn;
            k  = ($urandom_range(0, 2) == 0) ? CH_NUM'($urandom_range(0, 15)) : '0;
            mf = ($urandom_range(0, 9) == 0);
            rn = ($urandom_range(0, 63) != 0);
            applyStimulus(k, mf, rn, "random");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
